// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and the downstream consumer.
// The master side drives words in and applies backpressure; the slave side is
// the decode stage itself.
interface instr_decode_stage_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_pc;
    logic [31:0]          in_instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_pc;
    logic [6:0]           out_opcode;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic [4:0]           out_rd_addr;
    logic [4:0]           out_rs1_addr;
    logic [4:0]           out_rs2_addr;
    logic [31:0]          out_imm;
    logic                 out_rd_we;
    logic                 out_illegal;
    logic [CNT_WIDTH-1:0] out_count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd_addr, out_rs1_addr, out_rs2_addr, out_imm, out_rd_we,
               out_illegal, out_count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd_addr, out_rs1_addr, out_rs2_addr, out_imm, out_rd_we,
               out_illegal, out_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I decode pipeline stage. A main output register plus a one-entry skid
// register give full throughput under backpressure while in_ready stays a
// pure function of registered state. The skid holds the raw word; decoding is
// done on whichever source is about to load the main register.
module instr_decode_stage #(
    parameter int CNT_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush,
    instr_decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_VARIANT = 7'b0100000;

    logic                 skid_valid;
    logic [31:0]          skid_pc;
    logic [31:0]          skid_instr;

    logic                 out_valid_q;
    logic [31:0]          out_pc_q;
    logic [6:0]           opcode_q;
    logic [2:0]           funct3_q;
    logic [6:0]           funct7_q;
    logic [4:0]           rd_q;
    logic [4:0]           rs1_q;
    logic [4:0]           rs2_q;
    logic [31:0]          imm_q;
    logic                 rd_we_q;
    logic                 illegal_q;
    logic [CNT_WIDTH-1:0] count_q;

    logic                 accept;
    logic                 emit;
    logic                 main_load;

    logic [31:0]          src_pc;
    logic [31:0]          src_instr;
    logic [2:0]           src_f3;
    logic [6:0]           src_f7;
    logic                 has_rd;
    logic                 has_rs1;
    logic                 has_rs2;
    logic                 dec_illegal;
    logic [31:0]          raw_imm;
    logic [31:0]          dec_imm;
    logic [4:0]           dec_rd;
    logic [4:0]           dec_rs1;
    logic [4:0]           dec_rs2;
    logic                 dec_rd_we;

    assign accept    = bus.in_valid && !skid_valid;
    assign emit      = out_valid_q && bus.out_ready;
    assign main_load = !out_valid_q || bus.out_ready;

    // Decode the word that would load the main register: skid first for FIFO order.
    always_comb begin
        src_pc      = skid_valid ? skid_pc : bus.in_pc;
        src_instr   = skid_valid ? skid_instr : bus.in_instr;
        src_f3      = src_instr[14:12];
        src_f7      = src_instr[31:25];
        has_rd      = 1'b0;
        has_rs1     = 1'b0;
        has_rs2     = 1'b0;
        dec_illegal = 1'b0;
        raw_imm     = 32'd0;
        case (src_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                has_rd  = 1'b1;
                raw_imm = {src_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                has_rd  = 1'b1;
                raw_imm = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                           src_instr[20], src_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                has_rd      = 1'b1;
                has_rs1     = 1'b1;
                raw_imm     = {{20{src_instr[31]}}, src_instr[31:20]};
                dec_illegal = (src_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                has_rs1     = 1'b1;
                has_rs2     = 1'b1;
                raw_imm     = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                               src_instr[30:25], src_instr[11:8], 1'b0};
                dec_illegal = (src_f3 == 3'b010) || (src_f3 == 3'b011);
            end
            OPC_LOAD: begin
                has_rd      = 1'b1;
                has_rs1     = 1'b1;
                raw_imm     = {{20{src_instr[31]}}, src_instr[31:20]};
                dec_illegal = (src_f3 == 3'b011) || (src_f3 == 3'b110) || (src_f3 == 3'b111);
            end
            OPC_STORE: begin
                has_rs1     = 1'b1;
                has_rs2     = 1'b1;
                raw_imm     = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
                dec_illegal = (src_f3 >= 3'b011);
            end
            OPC_OPIMM: begin
                has_rd  = 1'b1;
                has_rs1 = 1'b1;
                raw_imm = {{20{src_instr[31]}}, src_instr[31:20]};
                if (src_f3 == 3'b001) begin
                    dec_illegal = (src_f7 != F7_BASE);
                end else if (src_f3 == 3'b101) begin
                    dec_illegal = (src_f7 != F7_BASE) && (src_f7 != F7_VARIANT);
                end
            end
            OPC_OP: begin
                has_rd  = 1'b1;
                has_rs1 = 1'b1;
                has_rs2 = 1'b1;
                if (src_f7 == F7_VARIANT) begin
                    dec_illegal = (src_f3 != 3'b000) && (src_f3 != 3'b101);
                end else begin
                    dec_illegal = (src_f7 != F7_BASE);
                end
            end
            default: dec_illegal = 1'b1;
        endcase
        dec_rd    = has_rd  ? src_instr[11:7]  : 5'd0;
        dec_rs1   = has_rs1 ? src_instr[19:15] : 5'd0;
        dec_rs2   = has_rs2 ? src_instr[24:20] : 5'd0;
        dec_imm   = dec_illegal ? 32'd0 : raw_imm;
        dec_rd_we = !dec_illegal && has_rd && (src_instr[11:7] != 5'd0);
    end

    // Main/skid register update and handshake counter; reset beats flush beats handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid  <= 1'b0;
            skid_pc     <= 32'd0;
            skid_instr  <= 32'd0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            opcode_q    <= 7'd0;
            funct3_q    <= 3'd0;
            funct7_q    <= 7'd0;
            rd_q        <= 5'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            imm_q       <= 32'd0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else if (flush) begin
            skid_valid  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (emit) begin
                count_q <= count_q + 1'b1;
            end
            if (main_load) begin
                out_valid_q <= skid_valid || accept;
                skid_valid  <= 1'b0;
                if (skid_valid || accept) begin
                    out_pc_q  <= src_pc;
                    opcode_q  <= src_instr[6:0];
                    funct3_q  <= src_f3;
                    funct7_q  <= src_f7;
                    rd_q      <= dec_rd;
                    rs1_q     <= dec_rs1;
                    rs2_q     <= dec_rs2;
                    imm_q     <= dec_imm;
                    rd_we_q   <= dec_rd_we;
                    illegal_q <= dec_illegal;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_pc    <= bus.in_pc;
                skid_instr <= bus.in_instr;
            end
        end
    end

    assign bus.in_ready     = !skid_valid;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_pc       = out_pc_q;
    assign bus.out_opcode   = opcode_q;
    assign bus.out_funct3   = funct3_q;
    assign bus.out_funct7   = funct7_q;
    assign bus.out_rd_addr  = rd_q;
    assign bus.out_rs1_addr = rs1_q;
    assign bus.out_rs2_addr = rs2_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_rd_we    = rd_we_q;
    assign bus.out_illegal  = illegal_q;
    assign bus.out_count    = count_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, skid/backpressure
// ordering, flush and counter wrap (a second instance with a 4-bit counter
// follows the same stimulus).
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   passes = 0;

    logic [31:0] emit_pc_q[$];
    logic [31:0] emit_imm_q[$];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rd_we;
        logic        illegal;
    } vec_t;

    always #5 clk = ~clk;

    instr_decode_stage_if #(.CNT_WIDTH(32)) aif ();
    instr_decode_stage_if #(.CNT_WIDTH(4))  bif ();

    assign bif.in_valid  = aif.in_valid;
    assign bif.in_pc     = aif.in_pc;
    assign bif.in_instr  = aif.in_instr;
    assign bif.out_ready = aif.out_ready;

    instr_decode_stage #(.CNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (aif)
    );

    instr_decode_stage #(.CNT_WIDTH(4)) dut_small (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bif)
    );

    // Record every output handshake of the wide instance in order.
    always @(posedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && aif.out_valid === 1'b1 && aif.out_ready === 1'b1) begin
            emit_pc_q.push_back(aif.out_pc);
            emit_imm_q.push_back(aif.out_imm);
        end
    end

    function automatic logic [31:0] make_addi(input int k);
        return (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst           = 1'b1;
        flush         = 1'b0;
        aif.in_valid  = 1'b0;
        aif.in_pc     = 32'd0;
        aif.in_instr  = 32'd0;
        aif.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (aif.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", aif.out_valid); else passes++;
        checks++; if (aif.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", aif.in_ready); else passes++;
        checks++; if (aif.out_count !== 32'd0) $display("[TB] FAIL reset_count: got %0d expected 0", aif.out_count); else passes++;
        checks++; if (aif.out_imm !== 32'd0 || aif.out_pc !== 32'd0 || aif.out_rd_we !== 1'b0)
            $display("[TB] FAIL reset_data: got imm=%h pc=%h we=%b expected zeros", aif.out_imm, aif.out_pc, aif.out_rd_we); else passes++;
        checks++; if (bif.out_count !== 4'd0) $display("[TB] FAIL reset_small_count: got %0d expected 0", bif.out_count); else passes++;
    endtask

    task automatic test_addi;
        do_reset();
        aif.out_ready = 1'b1;
        aif.in_valid  = 1'b1;
        aif.in_pc     = 32'h1000;
        aif.in_instr  = 32'hFFB10093;
        step();
        aif.in_valid = 1'b0;
        checks++; if (aif.out_valid !== 1'b1 || aif.out_pc !== 32'h1000) $display("[TB] FAIL addi_valid_pc: got v=%b pc=%h expected 1 00001000", aif.out_valid, aif.out_pc); else passes++;
        checks++; if (aif.out_rs1_addr !== 5'd2 || aif.out_rd_addr !== 5'd1 || aif.out_rs2_addr !== 5'd0)
            $display("[TB] FAIL addi_regs: got rs1=%0d rd=%0d rs2=%0d expected 2 1 0", aif.out_rs1_addr, aif.out_rd_addr, aif.out_rs2_addr); else passes++;
        checks++; if (aif.out_imm !== 32'hFFFFFFFB) $display("[TB] FAIL addi_imm: got %h expected fffffffb", aif.out_imm); else passes++;
        checks++; if (aif.out_rd_we !== 1'b1 || aif.out_illegal !== 1'b0) $display("[TB] FAIL addi_flags: got we=%b ill=%b expected 1 0", aif.out_rd_we, aif.out_illegal); else passes++;
        checks++; if (aif.out_opcode !== 7'h13 || aif.out_funct3 !== 3'd0 || aif.out_funct7 !== 7'h7F)
            $display("[TB] FAIL addi_fields: got op=%h f3=%h f7=%h expected 13 0 7f", aif.out_opcode, aif.out_funct3, aif.out_funct7); else passes++;
        step();
        checks++; if (aif.out_count !== 32'd1 || aif.out_valid !== 1'b0) $display("[TB] FAIL addi_count: got cnt=%0d v=%b expected 1 0", aif.out_count, aif.out_valid); else passes++;
    endtask

    task automatic test_back_to_back;
        do_reset();
        aif.out_ready = 1'b1;
        aif.in_valid  = 1'b1;
        aif.in_pc     = 32'h2000;
        aif.in_instr  = 32'hFE208CE3;
        step();
        aif.in_pc    = 32'h2004;
        aif.in_instr = 32'h123452B7;
        checks++; if (aif.out_imm !== 32'hFFFFFFF8) $display("[TB] FAIL beq_imm: got %h expected fffffff8", aif.out_imm); else passes++;
        checks++; if (aif.out_rs1_addr !== 5'd1 || aif.out_rs2_addr !== 5'd2 || aif.out_rd_addr !== 5'd0)
            $display("[TB] FAIL beq_regs: got rs1=%0d rs2=%0d rd=%0d expected 1 2 0", aif.out_rs1_addr, aif.out_rs2_addr, aif.out_rd_addr); else passes++;
        checks++; if (aif.out_rd_we !== 1'b0 || aif.out_illegal !== 1'b0) $display("[TB] FAIL beq_flags: got we=%b ill=%b expected 0 0", aif.out_rd_we, aif.out_illegal); else passes++;
        step();
        aif.in_valid = 1'b0;
        checks++; if (aif.out_pc !== 32'h2004 || aif.out_imm !== 32'h12345000) $display("[TB] FAIL lui_imm: got pc=%h imm=%h expected 00002004 12345000", aif.out_pc, aif.out_imm); else passes++;
        checks++; if (aif.out_rd_addr !== 5'd5 || aif.out_rs1_addr !== 5'd0 || aif.out_rd_we !== 1'b1)
            $display("[TB] FAIL lui_regs: got rd=%0d rs1=%0d we=%b expected 5 0 1", aif.out_rd_addr, aif.out_rs1_addr, aif.out_rd_we); else passes++;
        step();
        checks++; if (aif.out_count !== 32'd2) $display("[TB] FAIL b2b_count: got %0d expected 2", aif.out_count); else passes++;
    endtask

    task automatic test_illegal;
        do_reset();
        aif.out_ready = 1'b1;
        aif.in_valid  = 1'b1;
        aif.in_pc     = 32'h200;
        aif.in_instr  = 32'h0000007F;
        step();
        aif.in_pc    = 32'h204;
        aif.in_instr = 32'h40209033;
        checks++; if (aif.out_pc !== 32'h200 || aif.out_illegal !== 1'b1 || aif.out_rd_we !== 1'b0 || aif.out_imm !== 32'd0 || aif.out_opcode !== 7'h7F)
            $display("[TB] FAIL illegal_opcode: got pc=%h ill=%b we=%b imm=%h op=%h expected 200 1 0 0 7f", aif.out_pc, aif.out_illegal, aif.out_rd_we, aif.out_imm, aif.out_opcode); else passes++;
        step();
        aif.in_valid = 1'b0;
        checks++; if (aif.out_pc !== 32'h204 || aif.out_illegal !== 1'b1 || aif.out_rd_we !== 1'b0 || aif.out_imm !== 32'd0 || aif.out_opcode !== 7'h33)
            $display("[TB] FAIL illegal_sll_variant: got pc=%h ill=%b we=%b imm=%h op=%h expected 204 1 0 0 33", aif.out_pc, aif.out_illegal, aif.out_rd_we, aif.out_imm, aif.out_opcode); else passes++;
    endtask

    task automatic test_formats;
        vec_t vecs[10];
        vecs[0] = '{32'h00512623, 32'd12,         5'd0,  5'd2, 5'd5, 1'b0, 1'b0};
        vecs[1] = '{32'hFFDFF0EF, 32'hFFFFFFFC,   5'd1,  5'd0, 5'd0, 1'b1, 1'b0};
        vecs[2] = '{32'h4041D193, 32'h00000404,   5'd3,  5'd3, 5'd0, 1'b1, 1'b0};
        vecs[3] = '{32'h00000013, 32'd0,          5'd0,  5'd0, 5'd0, 1'b0, 1'b0};
        vecs[4] = '{32'h402081B3, 32'd0,          5'd3,  5'd1, 5'd2, 1'b1, 1'b0};
        vecs[5] = '{32'h80000517, 32'h80000000,   5'd10, 5'd0, 5'd0, 1'b1, 1'b0};
        vecs[6] = '{32'h000110E7, 32'd0,          5'd0,  5'd0, 5'd0, 1'b0, 1'b1};
        vecs[7] = '{32'h00013083, 32'd0,          5'd0,  5'd0, 5'd0, 1'b0, 1'b1};
        vecs[8] = '{32'h0020A063, 32'd0,          5'd0,  5'd0, 5'd0, 1'b0, 1'b1};
        vecs[9] = '{32'h40009093, 32'd0,          5'd0,  5'd0, 5'd0, 1'b0, 1'b1};
        do_reset();
        aif.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            aif.in_valid = 1'b1;
            aif.in_pc    = 32'h100 + 32'(i * 4);
            aif.in_instr = vecs[i].instr;
            step();
            checks++;
            if (aif.out_valid !== 1'b1 || aif.out_pc !== 32'h100 + 32'(i * 4) || aif.out_imm !== vecs[i].imm ||
                aif.out_rd_we !== vecs[i].rd_we || aif.out_illegal !== vecs[i].illegal)
                $display("[TB] FAIL fmt%0d_decode: got v=%b pc=%h imm=%h we=%b ill=%b expected 1 %h %h %b %b", i, aif.out_valid, aif.out_pc,
                         aif.out_imm, aif.out_rd_we, aif.out_illegal, 32'h100 + 32'(i * 4), vecs[i].imm, vecs[i].rd_we, vecs[i].illegal);
            else passes++;
            if (!vecs[i].illegal) begin
                checks++;
                if (aif.out_rd_addr !== vecs[i].rd || aif.out_rs1_addr !== vecs[i].rs1 || aif.out_rs2_addr !== vecs[i].rs2)
                    $display("[TB] FAIL fmt%0d_regs: got rd=%0d rs1=%0d rs2=%0d expected %0d %0d %0d", i, aif.out_rd_addr, aif.out_rs1_addr,
                             aif.out_rs2_addr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
                else passes++;
            end
        end
        aif.in_valid = 1'b0;
        step();
    endtask

    task automatic test_stream;
        int          idx;
        bit          took;
        bit          stalled;
        bit          saw_not_ready;
        logic [31:0] held_pc;
        logic [31:0] held_imm;
        do_reset();
        emit_pc_q.delete();
        emit_imm_q.delete();
        idx           = 0;
        saw_not_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && emit_pc_q.size() < 8; cyc++) begin
            aif.out_ready = !(cyc >= 2 && cyc <= 5);
            aif.in_valid  = (idx < 8);
            aif.in_pc     = 32'(idx * 4);
            aif.in_instr  = make_addi(idx);
            took          = aif.in_valid && aif.in_ready;
            if (aif.in_ready !== 1'b1) saw_not_ready = 1'b1;
            stalled  = (aif.out_valid === 1'b1) && !aif.out_ready;
            held_pc  = aif.out_pc;
            held_imm = aif.out_imm;
            step();
            if (took) idx++;
            if (stalled) begin
                checks++;
                if (aif.out_valid !== 1'b1 || aif.out_pc !== held_pc || aif.out_imm !== held_imm)
                    $display("[TB] FAIL stream_hold: got v=%b pc=%h imm=%h expected 1 %h %h", aif.out_valid, aif.out_pc, aif.out_imm, held_pc, held_imm);
                else passes++;
            end
        end
        aif.in_valid  = 1'b0;
        aif.out_ready = 1'b1;
        checks++; if (saw_not_ready !== 1'b1) $display("[TB] FAIL stream_backpressure: in_ready low seen=%b expected 1", saw_not_ready); else passes++;
        checks++; if (emit_pc_q.size() != 8) $display("[TB] FAIL stream_emit_count: got %0d expected 8", emit_pc_q.size()); else passes++;
        for (int i = 0; i < 8; i++) begin
            if (i < emit_pc_q.size()) begin
                checks++;
                if (emit_pc_q[i] !== 32'(i * 4) || emit_imm_q[i] !== 32'(i))
                    $display("[TB] FAIL stream_order%0d: got pc=%h imm=%h expected %h %h", i, emit_pc_q[i], emit_imm_q[i], 32'(i * 4), 32'(i));
                else passes++;
            end
        end
        checks++; if (aif.out_count !== 32'd8) $display("[TB] FAIL stream_count: got %0d expected 8", aif.out_count); else passes++;
    endtask

    task automatic test_flush;
        do_reset();
        emit_pc_q.delete();
        emit_imm_q.delete();
        aif.in_valid = 1'b1;
        aif.in_pc    = 32'h700;
        aif.in_instr = 32'h00000013;
        step();
        aif.in_pc = 32'h704;
        step();
        aif.in_valid = 1'b0;
        checks++; if (aif.in_ready !== 1'b0 || aif.out_valid !== 1'b1 || aif.out_pc !== 32'h700)
            $display("[TB] FAIL flush_fill: got rdy=%b v=%b pc=%h expected 0 1 700", aif.in_ready, aif.out_valid, aif.out_pc); else passes++;
        flush        = 1'b1;
        aif.in_valid = 1'b1;
        aif.in_pc    = 32'h77C;
        step();
        flush        = 1'b0;
        aif.in_valid = 1'b0;
        checks++; if (aif.out_valid !== 1'b0 || aif.in_ready !== 1'b1 || aif.out_count !== 32'd0)
            $display("[TB] FAIL flush_full: got v=%b rdy=%b cnt=%0d expected 0 1 0", aif.out_valid, aif.in_ready, aif.out_count); else passes++;
        aif.out_ready = 1'b1;
        repeat (3) step();
        checks++; if (emit_pc_q.size() != 0 || aif.out_valid !== 1'b0) $display("[TB] FAIL flush_drop: got emits=%0d v=%b expected 0 0", emit_pc_q.size(), aif.out_valid); else passes++;
        aif.in_valid = 1'b1;
        aif.in_pc    = 32'h7F0;
        step();
        aif.in_valid = 1'b0;
        step();
        aif.out_ready = 1'b0;
        aif.in_valid  = 1'b1;
        aif.in_pc     = 32'h800;
        step();
        flush        = 1'b1;
        aif.in_pc    = 32'h804;
        step();
        flush         = 1'b0;
        aif.in_valid  = 1'b0;
        aif.out_ready = 1'b1;
        checks++; if (aif.out_valid !== 1'b0 || aif.in_ready !== 1'b1 || aif.out_count !== 32'd1)
            $display("[TB] FAIL flush_main: got v=%b rdy=%b cnt=%0d expected 0 1 1", aif.out_valid, aif.in_ready, aif.out_count); else passes++;
        repeat (3) step();
        checks++; if (emit_pc_q.size() != 1 || aif.out_count !== 32'd1) $display("[TB] FAIL flush_main_drop: got emits=%0d cnt=%0d expected 1 1", emit_pc_q.size(), aif.out_count); else passes++;
        if (emit_pc_q.size() > 0) begin
            checks++; if (emit_pc_q[0] !== 32'h7F0) $display("[TB] FAIL flush_survivor: got pc=%h expected 7f0", emit_pc_q[0]); else passes++;
        end
    endtask

    task automatic test_wrap;
        do_reset();
        aif.out_ready = 1'b1;
        for (int e = 0; e < 18; e++) begin
            aif.in_valid = (e < 17);
            aif.in_pc    = 32'(e * 4);
            aif.in_instr = 32'h00000013;
            step();
            if (e == 15) begin
                checks++; if (bif.out_count !== 4'd15) $display("[TB] FAIL wrap_15: got %0d expected 15", bif.out_count); else passes++;
            end
            if (e == 16) begin
                checks++; if (bif.out_count !== 4'd0) $display("[TB] FAIL wrap_0: got %0d expected 0", bif.out_count); else passes++;
            end
        end
        aif.in_valid = 1'b0;
        checks++; if (bif.out_count !== 4'd1) $display("[TB] FAIL wrap_final: got %0d expected 1", bif.out_count); else passes++;
        checks++; if (aif.out_count !== 32'd17) $display("[TB] FAIL wrap_wide: got %0d expected 17", aif.out_count); else passes++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_formats();
        test_stream();
        test_flush();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
